// File: rtl/result_readback_if.sv
// Memory bar and output stream bundle for the result readback engine.
// master = readback engine, slave = memory plus downstream consumer.
interface result_readback_if #(
    parameter int WIDTH = 64
);
    logic             write_en_bar;
    logic [WIDTH-1:0] data_in_bar;
    logic [31:0]      addr_bar;
    logic [WIDTH-1:0] data_out_bar;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             m_last;

    modport master (
        output write_en_bar, data_in_bar, addr_bar, m_valid, m_data, m_last,
        input  data_out_bar, m_ready
    );

    modport slave (
        input  write_en_bar, data_in_bar, addr_bar, m_valid, m_data, m_last,
        output data_out_bar, m_ready
    );
endinterface

// File: rtl/result_readback.sv
// Drains a result region from the shared memory bar into a credit-bounded FIFO and streams it out.
// Optional macro STRIDED_READ_EN: read in column-interleaved order instead of linearly.
module result_readback #(
    parameter int WIDTH      = 64,
    parameter int BASE_ADDR  = 3072,
    parameter int NUM_WORDS  = 512,
    parameter int RD_LATENCY = 7,
    parameter int FIFO_DEPTH = 16,
    parameter int STRIDE     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    result_readback_if.master bar
);
    localparam int CW = $clog2(NUM_WORDS) + 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int OW = $clog2(RD_LATENCY + FIFO_DEPTH + 2) + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_WORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t           state_r;
    logic             busy_r;
    logic             done_r;
    logic [CW-1:0]    issue_cnt_r;
    logic [CW-1:0]    out_cnt_r;
    logic [31:0]      addr_r;
    logic             issue_v_r;
    logic [RD_LATENCY-1:0] pipe_r;
    logic [WIDTH-1:0] fifo_r [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [PW:0]      count_r;

    logic             valid_s;
    logic             push_s;
    logic             pop_s;
    logic             issue_s;
    logic [OW-1:0]    inflight_s;
    logic [OW-1:0]    credit_s;
    logic [31:0]      offset_s;

    function automatic logic [OW-1:0] ones_count(input logic [RD_LATENCY-1:0] v);
        logic [OW-1:0] n;
        n = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            n = n + OW'(v[i]);
        end
        return n;
    endfunction

    // Credit accounting: the address-stage flag counts as in flight so the FIFO can never overflow.
    always_comb begin
        valid_s    = (count_r != '0);
        push_s     = pipe_r[RD_LATENCY-1];
        pop_s      = valid_s && bar.m_ready;
        inflight_s = ones_count(pipe_r) + OW'(issue_v_r);
        credit_s   = inflight_s + OW'(count_r) - OW'(pop_s);
        if ((state_r == S_ISSUE) && (credit_s < OW'(FIFO_DEPTH))) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
    end

`ifdef STRIDED_READ_EN
    localparam int GROUP = NUM_WORDS / STRIDE;
    logic [CW-1:0] inner_r;
    logic [CW-1:0] outer_r;

    // Inner walks a column group in STRIDE steps; outer selects the column group.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inner_r <= '0;
            outer_r <= '0;
        end else if ((state_r == S_IDLE) && start) begin
            inner_r <= '0;
            outer_r <= '0;
        end else if (issue_s) begin
            if (inner_r == CW'(GROUP - 1)) begin
                inner_r <= '0;
                outer_r <= outer_r + CW'(1);
            end else begin
                inner_r <= inner_r + CW'(1);
            end
        end
    end

    assign offset_s = 32'(inner_r) * 32'(STRIDE) + 32'(outer_r);
`else
    assign offset_s = 32'(issue_cnt_r);
`endif

    // Control FSM with issue/beat counters and the address register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            issue_cnt_r <= '0;
            out_cnt_r   <= '0;
            addr_r      <= 32'(BASE_ADDR);
        end else begin
            if (pop_s) begin
                out_cnt_r <= out_cnt_r + CW'(1);
            end
            if (issue_s) begin
                addr_r      <= 32'(BASE_ADDR) + offset_s;
                issue_cnt_r <= issue_cnt_r + CW'(1);
            end
            case (state_r)
                S_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        state_r     <= S_ISSUE;
                        busy_r      <= 1'b1;
                        issue_cnt_r <= '0;
                        out_cnt_r   <= '0;
                    end
                end
                S_ISSUE: begin
                    if (issue_s && (issue_cnt_r == LAST_IDX)) begin
                        state_r <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (pop_s && (out_cnt_r == LAST_IDX) && (inflight_s == '0)) begin
                        state_r <= S_DONE;
                        done_r  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    // Read-latency tracker and output FIFO; a push into an empty FIFO is visible next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_v_r <= 1'b0;
            pipe_r    <= '0;
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            count_r   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_r[i] <= '0;
            end
        end else begin
            issue_v_r <= issue_s;
            pipe_r    <= (pipe_r << 1) | RD_LATENCY'(issue_v_r);
            if (push_s) begin
                fifo_r[wr_ptr_r] <= bar.data_out_bar;
                wr_ptr_r         <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            if (push_s && !pop_s) begin
                count_r <= count_r + (PW+1)'(1);
            end else if (!push_s && pop_s) begin
                count_r <= count_r - (PW+1)'(1);
            end
        end
    end

    assign busy             = busy_r;
    assign done             = done_r;
    assign bar.addr_bar     = addr_r;
    assign bar.write_en_bar = 1'b0;
    assign bar.data_in_bar  = '0;
    assign bar.m_valid      = valid_s;
    assign bar.m_data       = fifo_r[rd_ptr_r];
    assign bar.m_last       = valid_s && (out_cnt_r == LAST_IDX);

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_s && !pop_s && (count_r == (PW+1)'(FIFO_DEPTH))));
    a_stride_divides: assert property (@(posedge clk) disable iff (!rst_n)
        ((NUM_WORDS % STRIDE) == 0));
endmodule

// File: tb/tb_result_readback.sv
// Directed bench for result_readback: latency, backpressure, ignored restart and async reset abort.
module tb_result_readback;
    localparam int NW   = 512;
    localparam int LAT  = 7;
    localparam int BASE = 3072;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy;
    logic done;

    result_readback_if #(.WIDTH(64)) bus();

    result_readback #(
        .WIDTH(64), .BASE_ADDR(BASE), .NUM_WORDS(NW),
        .RD_LATENCY(LAT), .FIFO_DEPTH(16), .STRIDE(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .busy(busy), .done(done), .bar(bus)
    );

    always #5 clk = ~clk;

    logic [63:0] mem [0:4095];
    logic [63:0] dly [0:LAT-1];

    always @(posedge clk) begin
        dly[0] <= mem[bus.addr_bar[11:0]];
        for (int i = 1; i < LAT; i++) begin
            dly[i] <= dly[i-1];
        end
    end
    assign bus.data_out_bar = dly[LAT-1];

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] exp_val(input int n);
`ifdef STRIDED_READ_EN
        int q;
        q = NW / 4;
        return 64'((n % q) * 4 + n / q);
`else
        return 64'(n);
`endif
    endfunction

    int          beat;
    int          done_cnt;
    int          last_cnt;
    bit          mon_en = 1'b0;
    bit          hold_pend;
    logic [63:0] hold_data;

    // Stream monitor: ordering, m_last placement, stall stability, done count.
    initial forever begin
        @(negedge clk);
        if (mon_en && rst_n) begin
            if (hold_pend) begin
                check("hold_valid", 64'(bus.m_valid), 64'd1);
                check("hold_data", bus.m_data, hold_data);
            end
            hold_pend = bus.m_valid && !bus.m_ready;
            hold_data = bus.m_data;
            if (bus.m_valid) begin
                check("m_last", 64'(bus.m_last), 64'(beat == NW - 1));
                if (bus.m_ready) begin
                    check("m_data", bus.m_data, exp_val(beat));
                    if (bus.m_last) last_cnt++;
                    beat++;
                end
            end
            if (done) done_cnt++;
        end
    end

    task automatic reset_monitor();
        beat      = 0;
        done_cnt  = 0;
        last_cnt  = 0;
        hold_pend = 1'b0;
        mon_en    = 1'b1;
    endtask

    // mode 0: ready high; 1: ready 1-of-3; 2: ready low until cycle 100
    task automatic run_drain(input int mode, input int restart_at, output int first_v, output int n_done);
        first_v = -1;
        n_done  = -1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
        for (int n = 1; n <= 3000; n++) begin
            @(posedge clk); #1;
            if (bus.m_valid && first_v < 0) first_v = n;
            if (done) begin
                n_done = n;
                break;
            end
            if (mode == 1) bus.m_ready = (n % 3 == 0);
            if (mode == 2 && n == 100) begin
                check("stall_addr", 64'(bus.addr_bar), 64'(BASE) + exp_val(15));
                check("stall_valid", 64'(bus.m_valid), 64'd1);
                check("stall_head", bus.m_data, exp_val(0));
                check("stall_busy", 64'(busy), 64'd1);
                bus.m_ready = 1'b1;
            end
            start = (n == restart_at);
        end
        if (n_done < 0) check("done_timeout", 64'd0, 64'd1);
        start       = 1'b0;
        bus.m_ready = 1'b1;
        @(posedge clk); #1;
        check("done_pulse_width", 64'(done), 64'd0);
        check("busy_after_done", 64'(busy), 64'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_m_valid"}, 64'(bus.m_valid), 64'd0);
        check({tag, "_m_last"}, 64'(bus.m_last), 64'd0);
        check({tag, "_m_data"}, bus.m_data, 64'd0);
        check({tag, "_addr"}, 64'(bus.addr_bar), 64'd3072);
    endtask

    int fv;
    int nd;

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem[i] = (i >= BASE && i < BASE + NW) ? 64'(i - BASE) : 64'hFFFF_FFFF_FFFF_FFFF;
        end
        bus.m_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        check_reset_values("reset");
        check("write_en_bar", 64'(bus.write_en_bar), 64'd0);
        check("data_in_bar", bus.data_in_bar, 64'd0);

        // full-rate drain
        reset_monitor();
        run_drain(0, 0, fv, nd);
        check("a_first_valid", 64'(fv), 64'd9);
        check("a_done_cycle", 64'(nd), 64'd521);
        check("a_beats", 64'(beat), 64'd512);
        check("a_done_cnt", 64'(done_cnt), 64'd1);
        check("a_last_cnt", 64'(last_cnt), 64'd1);

        // 1-of-3 backpressure
        reset_monitor();
        run_drain(1, 0, fv, nd);
        check("b_beats", 64'(beat), 64'd512);
        check("b_done_cnt", 64'(done_cnt), 64'd1);
        check("b_last_cnt", 64'(last_cnt), 64'd1);

        // long stall right after start
        reset_monitor();
        bus.m_ready = 1'b0;
        run_drain(2, 0, fv, nd);
        check("c_beats", 64'(beat), 64'd512);
        check("c_done_cnt", 64'(done_cnt), 64'd1);

        // extra start at cycle 50 is ignored
        reset_monitor();
        run_drain(0, 50, fv, nd);
        check("d_done_cycle", 64'(nd), 64'd521);
        check("d_beats", 64'(beat), 64'd512);
        repeat (20) @(posedge clk);
        #1;
        check("d_done_cnt", 64'(done_cnt), 64'd1);
        check("d_idle_busy", 64'(busy), 64'd0);

        // async reset at beat 200, then a clean restart
        reset_monitor();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            if (beat >= 200) break;
            @(posedge clk); #1;
        end
        check("e_beat_at_reset", 64'(beat), 64'd200);
        #2;
        rst_n  = 1'b0;
        mon_en = 1'b0;
        #1;
        check_reset_values("e_async");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        reset_monitor();
        run_drain(0, 0, fv, nd);
        check("e_first_valid", 64'(fv), 64'd9);
        check("e_done_cycle", 64'(nd), 64'd521);
        check("e_beats", 64'(beat), 64'd512);
        check("e_done_cnt", 64'(done_cnt), 64'd1);

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
